// File: rtl/dec_pkg.sv
// =============================================================================
// Module  : dec_pkg
// Brief   : Shared state encoding and one-hot helper for the scan decoder.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package dec_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIRECT     = 2'd1,
        SCAN_ON    = 2'd2,
        SCAN_BLANK = 2'd3
    } dec_state_e;

    localparam int unsigned c_MAX_AW = 8;

    // Reference one-hot for any width up to c_MAX_AW; caller truncates to its NO.
    function automatic logic [(1 << c_MAX_AW)-1:0] onehot(input logic [c_MAX_AW-1:0] idx,
                                                          input int unsigned aw);
        onehot = '0;
        if ((aw <= c_MAX_AW) && (32'(idx) < (32'd1 << aw))) begin
            onehot[idx] = 1'b1;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_onehot.sv
// =============================================================================
// Module  : dec_onehot
// Brief   : Combinational AW-to-2**AW one-hot decoder with enable.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module dec_onehot
    import dec_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic                 en,
    input  logic [AW-1:0]        a,
    output logic [(2**AW)-1:0]   y
);

    localparam int NO = 2 ** AW;

    assign y = en ? (NO'(1) << a) : '0;

endmodule

`default_nettype wire

// File: rtl/dec_scan_seq.sv
// =============================================================================
// Module  : dec_scan_seq
// Brief   : Registered one-hot decoder with handshaked direct mode and a
//           dwell/blanking scan sequencer.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module dec_scan_seq
    import dec_pkg::*;
#(
    parameter int AW     = 3,
    parameter int DWELL  = 4,
    parameter int BLANK  = 1,
    parameter int ACT_LO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [AW-1:0]        a,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic [(2**AW)-1:0]   d,
    output logic                 d_valid,
    output logic [AW-1:0]        scan_idx,
    output logic                 wrap
);

    localparam int NO   = 2 ** AW;
    localparam int c_DW = $clog2(DWELL + 1);
    localparam int c_BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [NO-1:0]   c_POL        = (ACT_LO != 0) ? {NO{1'b1}} : {NO{1'b0}};
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL);
    localparam logic [c_BW-1:0] c_BLANK_LAST = c_BW'(BLANK);
    localparam logic [AW-1:0]   c_IDX_LAST   = AW'(NO - 1);

    dec_state_e        r_state, w_state_nxt;
    logic [NO-1:0]     r_d;
    logic [NO-1:0]     w_dec;
    logic              r_d_valid, w_d_valid_nxt;
    logic [AW-1:0]     r_scan_idx, w_idx_nxt, w_idx_adv;
    logic              r_wrap, w_wrap_nxt;
    logic [c_DW-1:0]   r_dwell, w_dwell_nxt;
    logic [c_BW-1:0]   r_blank, w_blank_nxt;
    logic              w_load, w_sel_en, w_advance, w_go_idle;
    logic [AW-1:0]     w_sel_addr;

    // One shared decoder; its address is steered from a or the scan index.
    dec_onehot #(.AW(AW)) u_dec (
        .en (w_sel_en),
        .a  (w_sel_addr),
        .y  (w_dec)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_sel_en      = 1'b0;
        w_sel_addr    = a;
        w_idx_nxt     = r_scan_idx;
        w_idx_adv     = r_scan_idx + AW'(1);
        w_dwell_nxt   = r_dwell;
        w_blank_nxt   = r_blank;
        w_wrap_nxt    = 1'b0;
        w_d_valid_nxt = r_d_valid;
        w_advance     = 1'b0;
        w_go_idle     = 1'b0;

        if (!en) begin
            w_go_idle = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mode) begin
                        w_state_nxt   = SCAN_ON;
                        w_idx_nxt     = '0;
                        w_sel_addr    = '0;
                        w_sel_en      = 1'b1;
                        w_load        = 1'b1;
                        w_d_valid_nxt = 1'b1;
                        w_dwell_nxt   = c_DW'(1);
                    end else begin
                        w_state_nxt = DIRECT;
                    end
                end
                DIRECT: begin
                    if (mode) begin
                        w_go_idle = 1'b1;
                    end else if (a_valid) begin
                        w_load        = 1'b1;
                        w_sel_en      = 1'b1;
                        w_sel_addr    = a;
                        w_d_valid_nxt = 1'b1;
                    end
                end
                SCAN_ON: begin
                    if (!mode) begin
                        w_go_idle = 1'b1;
                    end else if (r_dwell == c_DWELL_LAST) begin
                        if (BLANK > 0) begin
                            w_state_nxt   = SCAN_BLANK;
                            w_load        = 1'b1;
                            w_d_valid_nxt = 1'b0;
                            w_dwell_nxt   = '0;
                            w_blank_nxt   = c_BW'(1);
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_dwell_nxt = r_dwell + c_DW'(1);
                    end
                end
                SCAN_BLANK: begin
                    if (!mode) begin
                        w_go_idle = 1'b1;
                    end else if (r_blank == c_BLANK_LAST) begin
                        w_advance = 1'b1;
                    end else begin
                        w_blank_nxt = r_blank + c_BW'(1);
                    end
                end
                default: w_go_idle = 1'b1;
            endcase
        end

        if (w_advance) begin
            w_state_nxt   = SCAN_ON;
            w_idx_nxt     = w_idx_adv;
            w_sel_addr    = w_idx_adv;
            w_sel_en      = 1'b1;
            w_load        = 1'b1;
            w_d_valid_nxt = 1'b1;
            w_dwell_nxt   = c_DW'(1);
            w_blank_nxt   = '0;
            w_wrap_nxt    = (r_scan_idx == c_IDX_LAST);
        end

        // Loading with the decoder disabled is how d is forced inactive.
        if (w_go_idle) begin
            w_state_nxt   = IDLE;
            w_load        = 1'b1;
            w_sel_en      = 1'b0;
            w_d_valid_nxt = 1'b0;
            w_dwell_nxt   = '0;
            w_blank_nxt   = '0;
            w_wrap_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_d        <= c_POL;
            r_d_valid  <= 1'b0;
            r_scan_idx <= '0;
            r_wrap     <= 1'b0;
            r_dwell    <= '0;
            r_blank    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_d_valid  <= w_d_valid_nxt;
            r_scan_idx <= w_idx_nxt;
            r_wrap     <= w_wrap_nxt;
            r_dwell    <= w_dwell_nxt;
            r_blank    <= w_blank_nxt;
            if (w_load) begin
                r_d <= w_dec ^ c_POL;
            end
        end
    end

    assign a_ready  = (r_state == DIRECT) & en & ~mode;
    assign d        = r_d;
    assign d_valid  = r_d_valid;
    assign scan_idx = r_scan_idx;
    assign wrap     = r_wrap;

endmodule

`default_nettype wire
